// File: rtl/fb_arbiter.sv
// Framebuffer arbiter: shares one synchronous-read 256x8 display RAM between
// VGA scanout reads, atomic sprite read-XOR-write draws and whole-screen clears.
module fb_arbiter #(
    parameter logic [7:0] CLEAR_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vga_req,
    input  logic [7:0] vga_addr,
    output logic       vga_gnt,
    output logic       vga_rvalid,
    output logic [7:0] vga_rdata,
    input  logic       draw_req,
    input  logic [7:0] draw_addr,
    input  logic [7:0] draw_data,
    output logic       draw_ack,
    output logic       draw_collision,
    input  logic       clr_req,
    output logic       clr_busy,
    output logic       clr_done,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_VGA_RD, S_VGA_CAP, S_DRAW_RD, S_DRAW_MOD, S_DRAW_WR, S_CLEAR
    } state_e;

    state_e          state_q, state_d;
    logic            last_vga_q, last_vga_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   draw_data_q, draw_data_d;
    logic            vga_gnt_q, vga_gnt_d;
    logic            vga_rvalid_q, vga_rvalid_d;
    logic [DW-1:0]   vga_rdata_q, vga_rdata_d;
    logic            draw_ack_q, draw_ack_d;
    logic            draw_coll_q, draw_coll_d;
    logic            clr_busy_q, clr_busy_d;
    logic            clr_done_q, clr_done_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            mem_we_q, mem_we_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

    // A clear is waiting either as a fresh request or as a preempted clear to resume.
    logic clr_pend_c, drw_pend_c, vga_ok_c;
    assign clr_pend_c = clr_busy_q | clr_req;
    assign drw_pend_c = draw_req & ~clr_busy_q;
    assign vga_ok_c   = vga_req & ~(last_vga_q & (clr_pend_c | drw_pend_c));

    always_comb begin
        state_d      = state_q;
        last_vga_d   = last_vga_q;
        cnt_d        = cnt_q;
        draw_data_d  = draw_data_q;
        vga_gnt_d    = 1'b0;
        vga_rvalid_d = 1'b0;
        vga_rdata_d  = vga_rdata_q;
        draw_ack_d   = 1'b0;
        draw_coll_d  = 1'b0;
        clr_busy_d   = clr_busy_q;
        clr_done_d   = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (vga_ok_c) begin
                    state_d    = S_VGA_RD;
                    vga_gnt_d  = 1'b1;
                    mem_addr_d = vga_addr;
                    last_vga_d = 1'b1;
                end else if (clr_pend_c) begin
                    state_d     = S_CLEAR;
                    clr_busy_d  = 1'b1;
                    mem_addr_d  = cnt_q;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = CLEAR_VALUE;
                    cnt_d       = cnt_q + AW'(1);
                    last_vga_d  = 1'b0;
                end else if (drw_pend_c) begin
                    state_d     = S_DRAW_RD;
                    mem_addr_d  = draw_addr;
                    draw_data_d = draw_data;
                    last_vga_d  = 1'b0;
                end
            end
            S_VGA_RD: state_d = S_VGA_CAP;
            S_VGA_CAP: begin
                state_d      = S_IDLE;
                vga_rdata_d  = mem_rdata;
                vga_rvalid_d = 1'b1;
            end
            S_DRAW_RD: state_d = S_DRAW_MOD;
            S_DRAW_MOD: begin
                state_d     = S_DRAW_WR;
                mem_we_d    = 1'b1;
                mem_wdata_d = mem_rdata ^ draw_data_q;
                draw_ack_d  = 1'b1;
                draw_coll_d = |(mem_rdata & draw_data_q);
            end
            S_DRAW_WR: state_d = S_IDLE;
            S_CLEAR: begin
                // cnt_q wrapping to zero means address 255 is the write in flight.
                if (cnt_q == '0) begin
                    state_d    = S_IDLE;
                    clr_busy_d = 1'b0;
                    clr_done_d = 1'b1;
                end else if (vga_req) begin
                    state_d    = S_VGA_RD;
                    vga_gnt_d  = 1'b1;
                    mem_addr_d = vga_addr;
                    last_vga_d = 1'b1;
                end else begin
                    mem_addr_d  = cnt_q;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = CLEAR_VALUE;
                    cnt_d       = cnt_q + AW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_vga_q   <= 1'b0;
            cnt_q        <= '0;
            draw_data_q  <= '0;
            vga_gnt_q    <= 1'b0;
            vga_rvalid_q <= 1'b0;
            vga_rdata_q  <= '0;
            draw_ack_q   <= 1'b0;
            draw_coll_q  <= 1'b0;
            clr_busy_q   <= 1'b0;
            clr_done_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_vga_q   <= last_vga_d;
            cnt_q        <= cnt_d;
            draw_data_q  <= draw_data_d;
            vga_gnt_q    <= vga_gnt_d;
            vga_rvalid_q <= vga_rvalid_d;
            vga_rdata_q  <= vga_rdata_d;
            draw_ack_q   <= draw_ack_d;
            draw_coll_q  <= draw_coll_d;
            clr_busy_q   <= clr_busy_d;
            clr_done_q   <= clr_done_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign vga_gnt        = vga_gnt_q;
    assign vga_rvalid     = vga_rvalid_q;
    assign vga_rdata      = vga_rdata_q;
    assign draw_ack       = draw_ack_q;
    assign draw_collision = draw_coll_q;
    assign clr_busy       = clr_busy_q;
    assign clr_done       = clr_done_q;
    assign mem_addr       = mem_addr_q;
    assign mem_we         = mem_we_q;
    assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: RAM model, vector table, scoreboard queues
// and hand-written clear/reset/fairness sequences.
module tb_fb_arbiter;
    localparam logic [7:0] CV = 8'h00;

    logic       clk = 1'b0;
    logic       rst;
    logic       vga_req, vga_gnt, vga_rvalid;
    logic [7:0] vga_addr, vga_rdata;
    logic       draw_req, draw_ack, draw_collision;
    logic [7:0] draw_addr, draw_data;
    logic       clr_req, clr_busy, clr_done;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;

    logic [7:0] ram [256];
    logic       bk_we;
    logic [7:0] bk_addr, bk_data;

    int checks = 0;
    int errors = 0;
    bit bad_we = 1'b0;
    bit bad_coll = 1'b0;
    logic [7:0] vq[$];
    bit         dq[$];

    typedef struct {
        bit         is_draw;
        logic [7:0] addr;
        logic [7:0] pre;
        logic [7:0] data;
        logic [7:0] exp_val;
        bit         exp_coll;
    } vec_t;
    vec_t vecs[7];

    fb_arbiter #(.CLEAR_VALUE(CV)) dut (
        .clk(clk), .rst(rst),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .draw_req(draw_req), .draw_addr(draw_addr), .draw_data(draw_data),
        .draw_ack(draw_ack), .draw_collision(draw_collision),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM; the bench back door only writes when the DUT does not.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else if (bk_we) ram[bk_addr] <= bk_data;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_le(input string nm, input int act, input int lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s: got %0d expected <= %0d", nm, act, lim);
        end
    endtask

    // Advance to the next falling edge and retire any scoreboard entries.
    task automatic step();
        @(negedge clk);
        if (mem_we && !(clr_busy || draw_ack)) bad_we = 1'b1;
        if (draw_collision && !draw_ack) bad_coll = 1'b1;
        if (vga_rvalid) begin
            chk("vga_sb_nonempty", int'(vq.size() != 0), 1);
            if (vq.size() != 0) chk("vga_rdata", vga_rdata, vq.pop_front());
        end
        if (draw_ack) begin
            chk("draw_sb_nonempty", int'(dq.size() != 0), 1);
            if (dq.size() != 0) chk("draw_collision", draw_collision, dq.pop_front());
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        bk_addr = a; bk_data = d; bk_we = 1'b1;
        step();
        bk_we = 1'b0;
    endtask

    task automatic fill_ee();
        for (int a = 0; a < 256; a++) preload(8'(a), 8'hEE);
    endtask

    task automatic clear_run(input bit preempt, input logic [7:0] va,
                             output int done_k, output int ngnt, output int resume_addr);
        int exp_a;
        int seq_err;
        exp_a = 0; seq_err = 0; done_k = 0; ngnt = 0; resume_addr = -1;
        clr_req = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            step();
            if (k == 1) clr_req = 1'b0;
            if (mem_we) begin
                if (int'(mem_addr) != exp_a) seq_err++;
                exp_a++;
                if (ngnt > 0 && resume_addr < 0) resume_addr = int'(mem_addr);
            end
            if (vga_gnt) begin
                ngnt++;
                vga_req = 1'b0;
            end
            if (preempt && mem_we && mem_addr == 8'd99 && ngnt == 0 && !vga_req) begin
                vga_addr = va; vga_req = 1'b1;
                vq.push_back(ram[va]);
            end
            if (clr_done) begin
                done_k = k;
                break;
            end
        end
        chk("clr_addr_seq_errs", seq_err, 0);
        chk("clr_write_count", exp_a, 256);
        chk("clr_busy_at_done", clr_busy, 0);
    endtask

    initial begin
        int kg, kv, ka, kd, nv, nd, last_rv, dreq_k, pat, bad, ngnt, ra;
        bit seen_we, seen_done, busy_seen;

        vecs[0] = '{1'b0, 8'h25, 8'hA5, 8'h00, 8'hA5, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 8'h5A, 8'h00, 8'h5A, 1'b0};
        vecs[2] = '{1'b0, 8'hFF, 8'h81, 8'h00, 8'h81, 1'b0};
        vecs[3] = '{1'b1, 8'h10, 8'h3C, 8'h0F, 8'h33, 1'b1};
        vecs[4] = '{1'b1, 8'h10, 8'h33, 8'hC0, 8'hF3, 1'b0};
        vecs[5] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b1};
        vecs[6] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};

        rst = 1'b0;
        vga_req = 1'b0; vga_addr = 8'h00;
        draw_req = 1'b0; draw_addr = 8'h00; draw_data = 8'h00;
        clr_req = 1'b0; bk_we = 1'b0; bk_addr = 8'h00; bk_data = 8'h00;
        step(); step();
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_vga_rdata", vga_rdata, 0);
        chk("rst_pulses", {vga_gnt, vga_rvalid, draw_ack, draw_collision, clr_busy, clr_done}, 0);
        rst = 1'b1;
        step();

        // Single-transaction vectors with latency checks.
        foreach (vecs[i]) begin
            preload(vecs[i].addr, vecs[i].pre);
            step();
            kg = 0; kv = 0; ka = 0;
            if (!vecs[i].is_draw) begin
                vga_addr = vecs[i].addr; vga_req = 1'b1;
                vq.push_back(vecs[i].exp_val);
                for (int k = 1; k <= 8; k++) begin
                    step();
                    if (k == 1) chk("vga_mem_addr", mem_addr, vecs[i].addr);
                    if (vga_gnt && kg == 0) begin kg = k; vga_req = 1'b0; vga_addr = 8'h77; end
                    if (vga_rvalid && kv == 0) kv = k;
                end
                chk("vga_gnt_latency", kg, 1);
                chk("vga_rvalid_latency", kv, 3);
            end else begin
                draw_addr = vecs[i].addr; draw_data = vecs[i].data; draw_req = 1'b1;
                dq.push_back(vecs[i].exp_coll);
                for (int k = 1; k <= 8; k++) begin
                    step();
                    if (k == 1) begin
                        chk("draw_rd_addr", {mem_we, mem_addr}, {1'b0, vecs[i].addr});
                        draw_addr = 8'h77; draw_data = 8'hFF;
                    end
                    if (draw_ack && ka == 0) begin
                        ka = k; draw_req = 1'b0;
                        chk("draw_wr", {mem_we, mem_addr, mem_wdata},
                            {1'b1, vecs[i].addr, vecs[i].exp_val});
                    end
                end
                chk("draw_ack_latency", ka, 3);
                chk("draw_ram_result", ram[vecs[i].addr], vecs[i].exp_val);
            end
        end

        // Fairness: VGA held continuously while two draws queue behind it.
        preload(8'h30, 8'h11); preload(8'h31, 8'h22); preload(8'h32, 8'h33);
        preload(8'h40, 8'hAA); preload(8'h41, 8'h0F);
        step();
        nv = 0; nd = 0; last_rv = 0; dreq_k = 0; pat = 0;
        vga_addr = 8'h30; vga_req = 1'b1; vq.push_back(ram[8'h30]);
        draw_addr = 8'h40; draw_data = 8'h0F; draw_req = 1'b1; dq.push_back(1'b1);
        for (int k = 1; k <= 40; k++) begin
            step();
            if (vga_gnt) begin
                if (nv > 0) chk_le("vga_accept_after_rvalid", k - 1 - last_rv, 4);
                pat = (pat << 1);
                nv++;
                if (nv < 3) begin
                    vga_addr = 8'(8'h30 + nv); vq.push_back(ram[8'(8'h30 + nv)]);
                end else vga_req = 1'b0;
            end
            if (vga_rvalid) last_rv = k;
            if (draw_ack) begin
                chk_le("draw_wait", k - dreq_k, 8);
                pat = (pat << 1) | 1;
                nd++;
                if (nd < 2) begin
                    draw_addr = 8'h41; draw_data = 8'hF0; dq.push_back(1'b0); dreq_k = k;
                end else draw_req = 1'b0;
            end
        end
        chk("fair_grant_order", pat, 5'b01010);
        chk("fair_ram_40", ram[8'h40], 8'hA5);
        chk("fair_ram_41", ram[8'h41], 8'hFF);

        // Asynchronous reset in the middle of a clear.
        fill_ee();
        step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        chk("clr_start", {clr_busy, mem_we, mem_addr}, {1'b1, 1'b1, 8'h00});
        repeat (50) step();
        chk("clr_mid_addr", mem_addr, 50);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_outs", {clr_busy, mem_we, mem_addr, clr_done}, 0);
        step();
        rst = 1'b1;
        seen_we = 1'b0; seen_done = 1'b0;
        repeat (5) begin
            step();
            if (mem_we) seen_we = 1'b1;
            if (clr_done) seen_done = 1'b1;
        end
        chk("rst_no_writes", seen_we, 0);
        chk("rst_no_done", seen_done, 0);
        chk("rst_ram_40_cleared", ram[40], CV);
        chk("rst_ram_50_untouched", ram[50], 8'hEE);
        chk("rst_ram_60_untouched", ram[60], 8'hEE);

        // Fresh clear after reset starts at address 0 and takes 256 writes.
        clear_run(1'b0, 8'h00, kd, ngnt, ra);
        chk("clr_done_cycle", kd, 257);
        chk("clr_no_vga", ngnt, 0);

        // Clear preempted by a single VGA read while address 99 is written.
        fill_ee();
        step();
        clear_run(1'b1, 8'hC8, kd, ngnt, ra);
        chk("pre_done_cycle", kd, 260);
        chk("pre_vga_grants", ngnt, 1);
        chk("pre_resume_addr", ra, 100);
        step(); step();
        bad = 0;
        for (int a = 0; a < 256; a++) if (ram[a] != CV) bad++;
        chk("pre_ram_cleared", bad, 0);

        // Clear and draw together; a clr_req pulse during busy is ignored.
        clr_req = 1'b1;
        draw_addr = 8'h20; draw_data = 8'h81; draw_req = 1'b1; dq.push_back(1'b0);
        kd = 0; ka = 0;
        for (int k = 1; k <= 400; k++) begin
            step();
            if (k == 1) begin
                clr_req = 1'b0;
                chk("sim_clear_first", {clr_busy, mem_addr}, {1'b1, 8'h00});
            end
            if (k == 150) clr_req = 1'b1;
            if (k == 151) clr_req = 1'b0;
            if (clr_done) kd = k;
            if (draw_ack && ka == 0) begin ka = k; draw_req = 1'b0; end
            if (ka != 0) break;
        end
        chk("sim_clr_done_cycle", kd, 257);
        chk("sim_draw_after_clear", int'(ka > kd), 1);
        chk_le("sim_draw_ack_delay", ka - kd, 4);
        busy_seen = 1'b0;
        repeat (5) begin
            step();
            if (clr_busy) busy_seen = 1'b1;
        end
        chk("sim_pulse_ignored", busy_seen, 0);
        chk("sim_ram_20", ram[8'h20], 8'h81);

        step(); step();
        chk("vga_sb_drained", vq.size(), 0);
        chk("draw_sb_drained", dq.size(), 0);
        chk("stray_mem_we", bad_we, 0);
        chk("stray_collision", bad_coll, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
